// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - RISC-V MEM stage: req/ack data-memory access, lane steering, MEM/WB register
// Optional MISALIGN_TRAP_EN: flag misaligned halfword/word accesses instead of aligning them down.
module mem_stage_access_unit (
    input  logic        clk,
    input  logic        rstN,
    input  logic        memWrite_MEM_IN,
    input  logic        memRead_MEM_IN,
    input  logic        regWrite_MEM_IN,
    input  logic        memToRegWrite_MEM_IN,
    input  logic [2:0]  func3_MEM_IN,
    input  logic [31:0] aluOut_MEM_IN,
    input  logic [31:0] storeData_MEM_IN,
    input  logic [4:0]  rd_MEM_IN,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWdata,
    input  logic [31:0] dmemRdata,
    input  logic        dmemAck,
    output logic        stall_MEM_Out,
    output logic        regWrite_WB_Out,
    output logic        memToRegWrite_WB_Out,
    output logic [31:0] loadData_WB_Out,
    output logic [31:0] aluOut_WB_Out,
    output logic [4:0]  rd_WB_Out,
    output logic        misaligned_WB_Out
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [4:0]  rd_q, rd_d;

    logic        is_access, is_byte, is_half, is_word, misaligned, pending;
    logic [1:0]  lane;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    assign lane      = aluOut_MEM_IN[1:0];
    assign is_access = memRead_MEM_IN | memWrite_MEM_IN;
    assign is_byte   = (func3_MEM_IN[1:0] == 2'b00);
    assign is_half   = (func3_MEM_IN[1:0] == 2'b01);
    assign is_word   = func3_MEM_IN[1];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_access & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign pending       = is_access & ~misaligned;
    // Reset gates the request combinationally so an aborted access drops at once.
    assign dmemReq       = rstN & (pending | (state_q == S_WAIT));
    assign dmemWe        = memWrite_MEM_IN;
    assign dmemAddr      = {aluOut_MEM_IN[31:2], 2'b00};
    assign stall_MEM_Out = dmemReq & ~dmemAck;

    always_comb begin
        dmemBe    = 4'b1111;
        dmemWdata = storeData_MEM_IN;
        if (is_byte) begin
            dmemBe    = 4'b0001 << lane;
            dmemWdata = {4{storeData_MEM_IN[7:0]}};
        end else if (is_half) begin
            dmemBe    = 4'b0011 << {lane[1], 1'b0};
            dmemWdata = {2{storeData_MEM_IN[15:0]}};
        end
    end

    always_comb begin
        rbyte = dmemRdata[7:0];
        case (lane)
            2'd0: rbyte = dmemRdata[7:0];
            2'd1: rbyte = dmemRdata[15:8];
            2'd2: rbyte = dmemRdata[23:16];
            2'd3: rbyte = dmemRdata[31:24];
            default: rbyte = dmemRdata[7:0];
        endcase
        rhalf    = lane[1] ? dmemRdata[31:16] : dmemRdata[15:0];
        load_ext = dmemRdata;
        if (is_byte) begin
            load_ext = func3_MEM_IN[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
        end else if (is_half) begin
            load_ext = func3_MEM_IN[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dmemReq && !dmemAck) state_d = S_WAIT;
            S_WAIT:  if (dmemAck) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A stalled edge loads a bubble; otherwise the MEM/WB register captures this instruction.
    always_comb begin
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        misaligned_d = 1'b0;
        load_data_d  = 32'd0;
        alu_out_d    = 32'd0;
        rd_d         = 5'd0;
        if (!stall_MEM_Out) begin
            reg_write_d  = regWrite_MEM_IN & ~misaligned;
            mem_to_reg_d = memToRegWrite_MEM_IN & ~misaligned;
            misaligned_d = misaligned;
            load_data_d  = (pending && memRead_MEM_IN && !memWrite_MEM_IN) ? load_ext : 32'd0;
            alu_out_d    = aluOut_MEM_IN;
            rd_d         = rd_MEM_IN;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= S_IDLE;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= 32'd0;
            alu_out_q    <= 32'd0;
            rd_q         <= 5'd0;
        end else begin
            state_q      <= state_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            misaligned_q <= misaligned_d;
            load_data_q  <= load_data_d;
            alu_out_q    <= alu_out_d;
            rd_q         <= rd_d;
        end
    end

    assign regWrite_WB_Out      = reg_write_q;
    assign memToRegWrite_WB_Out = mem_to_reg_q;
    assign misaligned_WB_Out    = misaligned_q;
    assign loadData_WB_Out      = load_data_q;
    assign aluOut_WB_Out        = alu_out_q;
    assign rd_WB_Out            = rd_q;
endmodule

// File: doc/mem_stage_access_unit.md
# mem_stage_access_unit

Memory-stage engine of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and performs loads and stores over a req/ack data-memory port with variable latency. It generates byte enables and store lane replication, and sign/zero-extends load data. It stalls the front of the pipeline while an access is outstanding and drives the MEM/WB register.

## Interface
- Parameters: none; data and address widths are fixed at 32 bits.
- `clk`  in  1  single clock; all state on rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `memWrite_MEM_IN`, `memRead_MEM_IN`  in  1 each  access type from EX/MEM.
- `regWrite_MEM_IN`, `memToRegWrite_MEM_IN`  in  1 each  writeback controls from EX/MEM.
- `func3_MEM_IN`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `aluOut_MEM_IN`  in  32  effective byte address, or ALU result.
- `storeData_MEM_IN`  in  32  rs2 value to store, low-aligned.
- `rd_MEM_IN`  in  regName_t (5)  destination register.
- `dmemReq`  out  1  access request.
- `dmemWe`  out  1  1 = write, 0 = read.
- `dmemAddr`  out  32  word address: `{aluOut[31:2], 2'b00}`.
- `dmemBe`  out  4  byte-lane enables.
- `dmemWdata`  out  32  lane-replicated store data.
- `dmemRdata`  in  32  read data, valid in the cycle `dmemAck` is high.
- `dmemAck`  in  1  access complete. Ignored while `dmemReq` is 0.
- `stall_MEM_Out`  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `regWrite_WB_Out`, `memToRegWrite_WB_Out`  out  1 each  registered writeback controls.
- `loadData_WB_Out`, `aluOut_WB_Out`  out  32 each  registered load result and ALU result.
- `rd_WB_Out`  out  regName_t  registered destination register.
- `misaligned_WB_Out`  out  1  registered misaligned-access flag.

## Operation
- Access pending = `memRead_MEM_IN | memWrite_MEM_IN`, and not misaligned (see Configuration). If read and write are both high, the access is treated as a write.
- FSM states: IDLE and WAIT.
  - IDLE with access pending: assert `dmemReq` combinationally. If `dmemAck` is high in the same cycle, the access completes and the FSM stays in IDLE. Otherwise it moves to WAIT.
  - WAIT: `dmemReq` stays high with address, data, enables and `dmemWe` stable. On `dmemAck` the FSM returns to IDLE.
- `stall_MEM_Out = dmemReq & ~dmemAck`. The upstream stages hold their inputs stable while it is high.
- Byte enables:
  - Byte access: `4'b0001 << addr[1:0]`.
  - Halfword access: `4'b0011 << {addr[1],1'b0}`.
  - Word access: `4'b1111`.
  - func3 values 011, 110 and 111 are treated as word.
  - The same enables are driven for reads and writes.
- Store data: a byte is replicated to all 4 lanes; a halfword is replicated to both halves; a word passes through unchanged.
- Load data: the addressed lane of `dmemRdata` is selected by `addr[1:0]`. LB and LH sign-extend; LBU and LHU zero-extend.
- MEM/WB register, on each non-stalled edge: captures the controls, rd and aluOut. `loadData_WB_Out` captures the extended load for reads, otherwise 0.
- MEM/WB register, on each stalled edge: inserts a bubble. `regWrite_WB_Out`, `memToRegWrite_WB_Out` and `misaligned_WB_Out` are 0; `rd_WB_Out`, `loadData_WB_Out` and `aluOut_WB_Out` are 0.
- Non-memory instructions pass through with no request and no stall.

## Timing
- Reset: every output register is 0 and the FSM is in IDLE. `dmemReq` and `stall_MEM_Out` are forced to 0 while `rstN` is low, including when reset asserts mid-access.
- Zero-wait ack (ack in the request cycle): no stall. The WB outputs update on the next edge, so MEM-to-WB latency is 1 cycle.
- Ack k cycles after the request first rises: `stall_MEM_Out` is high for exactly k cycles. Results are captured on the edge ending the ack cycle.
- Back-to-back accesses: a new request is issued in the cycle after the ack with no idle gap. `dmemReq` may therefore stay high across instructions.
- `dmemAck` high while in IDLE with no pending access is ignored.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]=1`, or a word access with `addr[1:0]!=0`, is misaligned.
  - A misaligned access raises no request and no stall.
  - The next edge sets `misaligned_WB_Out=1` and forces `regWrite_WB_Out=0` and `memToRegWrite_WB_Out=0`.
- `MISALIGN_TRAP_EN` undefined:
  - Misaligned addresses are aligned down: halfword ignores `addr[0]`, word ignores `addr[1:0]`.
  - `misaligned_WB_Out` is tied to 0.

## Test plan
- SW: addr 0x104, data 0xDEADBEEF, zero-wait ack -> `dmemAddr`=0x104, `dmemBe`=1111, `dmemWdata`=0xDEADBEEF, `dmemWe`=1; `stall_MEM_Out` never high.
- SB: addr 0x203, data 0x000000A5, ack after 3 cycles -> `dmemAddr`=0x200, `dmemBe`=1000, `dmemWdata`=0xA5A5A5A5; stall high for exactly 3 cycles; WB outputs are bubbles during the stall.
- LB at addr 0x1, `dmemRdata`=0x00008000 (byte 0x80) -> `loadData_WB_Out`=0xFFFFFF80. LBU with the same data -> 0x00000080. LH at addr 0x2, `dmemRdata`=0x80010000 -> 0xFFFF8001.
- Back-to-back LW then SW, 1-cycle ack latency -> `dmemReq` stays high across both accesses; 2 stall cycles total; LW result written with the correct rd.
- Assert `rstN` low during WAIT -> `dmemReq`, `stall_MEM_Out` and all WB outputs drop to 0 immediately. After release the FSM is in IDLE and a new access proceeds normally.
- With `MISALIGN_TRAP_EN`, LW at 0x102 -> no `dmemReq`, `misaligned_WB_Out`=1, `regWrite_WB_Out`=0. Without the macro -> `dmemAddr`=0x100 and the load completes.
